// File: rtl/m_stage_mem_pkg.sv
// mips_defs: opcode constants and the access-width type shared by the
// memory stage and its byte-lane helper.
package mips_defs;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } width_e;

  // Words need addr[1:0]==0 and halfwords need addr[0]==0.
  // Bytes are always aligned.
  function automatic logic is_misaligned(width_e w, logic [1:0] a);
    case (w)
      WORD:    return a != 2'b00;
      HALF:    return a[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/m_stage_mem_if.sv
// m_stage_mem_if: the E/M inputs and the M/W outputs of the memory stage.
//   master - upstream pipeline side: drives the *_M signals and reads the W signals.
//   slave  - the memory stage itself.
interface m_stage_mem_if;
  logic [31:0] Instr_M_in;
  logic [31:0] ALUout_M;
  logic [31:0] RT_M_in;
  logic [4:0]  A3_M_in;
  logic [31:0] PC4_M_in;
  logic [31:0] PC8_M_in;
  logic [31:0] Instr_W_in;
  logic [31:0] ALUout_W;
  logic [31:0] DMout_W;
  logic [4:0]  A3_W_in;
  logic [31:0] PC8_W_in;
  logic        align_err_W;

  modport master (
    output Instr_M_in, ALUout_M, RT_M_in, A3_M_in, PC4_M_in, PC8_M_in,
    input  Instr_W_in, ALUout_W, DMout_W, A3_W_in, PC8_W_in, align_err_W
  );

  modport slave (
    input  Instr_M_in, ALUout_M, RT_M_in, A3_M_in, PC4_M_in, PC8_M_in,
    output Instr_W_in, ALUout_W, DMout_W, A3_W_in, PC8_W_in, align_err_W
  );
endinterface

// File: rtl/m_stage_mem_dm_byte_lane.sv
// dm_byte_lane: combinational little-endian store merge and load extract.
//   width_i    - access width (BYTE/HALF/WORD)
//   signed_i   - sign-extend the loaded byte or halfword
//   addr_lo_i  - byte offset inside the word
//   old_word_i - current memory word
//   st_data_i  - store data (low bits used for sb/sh)
//   merged_o   - word to write back for a store
//   load_o     - extended load result
module dm_byte_lane
  import mips_defs::*;
(
  input  width_e      width_i,
  input  logic        signed_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] old_word_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] merged_o,
  output logic [31:0] load_o
);

  // Replicate the store data so every lane sees its candidate byte.
  logic [31:0] st_lanes;
  always_comb begin
    case (width_i)
      BYTE:    st_lanes = {4{st_data_i[7:0]}};
      HALF:    st_lanes = {2{st_data_i[15:0]}};
      default: st_lanes = st_data_i;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic lane_en;
      assign lane_en = (width_i == WORD) ||
                       ((width_i == HALF) && (addr_lo_i[1] == 1'((gi >> 1) & 1))) ||
                       ((width_i == BYTE) && (addr_lo_i == 2'(gi)));
      assign merged_o[gi*8 +: 8] = lane_en ? st_lanes[gi*8 +: 8] : old_word_i[gi*8 +: 8];
    end
  endgenerate

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  assign byte_sel = old_word_i[{addr_lo_i, 3'b000} +: 8];
  assign half_sel = addr_lo_i[1] ? old_word_i[31:16] : old_word_i[15:0];

  always_comb begin
    case (width_i)
      BYTE:    load_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      HALF:    load_o = {{16{signed_i & half_sel[15]}}, half_sel};
      default: load_o = old_word_i;
    endcase
  end

endmodule

// File: rtl/m_stage_mem.sv
// m_stage_mem: the memory stage of the five-stage MIPS pipeline.
// It decodes loads and stores, accesses the data memory, and registers
// the M/W pipeline state.
//   clk   - pipeline clock
//   reset - asynchronous, active-high; clears the M/W state and every memory word
//   bus   - slave side of m_stage_mem_if (E/M inputs, M/W outputs)
module m_stage_mem
  import mips_defs::*;
#(
  parameter int DM_WORDS = 1024
) (
  input  logic          clk,
  input  logic          reset,
  m_stage_mem_if.slave  bus
);

  localparam int IDX_W = $clog2(DM_WORDS);

  logic [31:0] mem_q [DM_WORDS];

  // Decode
  logic   is_load, is_store, sgn, misaligned, store_en;
  width_e width;
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sgn      = 1'b0;
    width    = WORD;
    case (bus.Instr_M_in[31:26])
      OP_LW:  begin is_load  = 1'b1; width = WORD; end
      OP_LB:  begin is_load  = 1'b1; width = BYTE; sgn = 1'b1; end
      OP_LBU: begin is_load  = 1'b1; width = BYTE; end
      OP_LH:  begin is_load  = 1'b1; width = HALF; sgn = 1'b1; end
      OP_LHU: begin is_load  = 1'b1; width = HALF; end
      OP_SW:  begin is_store = 1'b1; width = WORD; end
      OP_SH:  begin is_store = 1'b1; width = HALF; end
      OP_SB:  begin is_store = 1'b1; width = BYTE; end
      default: ;
    endcase
  end

  assign misaligned = (is_load || is_store) && is_misaligned(width, bus.ALUout_M[1:0]);
  assign store_en   = is_store && !misaligned;

  // Address bits above the index are dropped, so addresses wrap.
  logic [IDX_W-1:0] idx;
  logic [31:0]      rd_word, merged_word, load_word;
  assign idx     = bus.ALUout_M[IDX_W+1:2];
  assign rd_word = mem_q[idx];

  dm_byte_lane u_lane (
    .width_i    (width),
    .signed_i   (sgn),
    .addr_lo_i  (bus.ALUout_M[1:0]),
    .old_word_i (rd_word),
    .st_data_i  (bus.RT_M_in),
    .merged_o   (merged_word),
    .load_o     (load_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) mem_q[i] <= '0;
    end else if (store_en) begin
      mem_q[idx] <= merged_word;
    end
  end

  // M/W pipeline register
  logic [31:0] instr_q, aluout_q, dmout_q, pc8_q;
  logic [31:0] dmout_d;
  logic [4:0]  a3_q;
  logic        err_q;

  // A misaligned load and a non-load both return 0.
  assign dmout_d = (is_load && !misaligned) ? load_word : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q  <= '0;
      aluout_q <= '0;
      dmout_q  <= '0;
      pc8_q    <= '0;
      a3_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      instr_q  <= bus.Instr_M_in;
      aluout_q <= bus.ALUout_M;
      dmout_q  <= dmout_d;
      pc8_q    <= bus.PC8_M_in;
      a3_q     <= bus.A3_M_in;
      err_q    <= misaligned;
    end
  end

  assign bus.Instr_W_in  = instr_q;
  assign bus.ALUout_W    = aluout_q;
  assign bus.DMout_W     = dmout_q;
  assign bus.A3_W_in     = a3_q;
  assign bus.PC8_W_in    = pc8_q;
  assign bus.align_err_W = err_q;

`ifndef SYNTHESIS
  // Store trace. It is simulation only and is skipped while reset holds.
  always @(posedge clk) begin
    if (!reset && store_en)
      $display("@%h: *%h <= %h", bus.PC4_M_in - 32'd4,
               {bus.ALUout_M[31:2], 2'b00}, merged_word);
  end
`endif

endmodule
